rtc_calendar: RTL and testbench
===============================

Name: rtc_calendar

Overview:
- Calendar stage downstream of the RTC counter block; consumes its one-cycle seconds tick.
- Maintains BCD-free binary date/time fields: sec, min, hour, day, month, year (offset from 2000), and weekday.
- Provides a validated load port, carry event pulses and a daily hh:mm:ss alarm.
- Single clock domain; the tick must already be synchronised into clk_i.

Parameters:
YEAR_WIDTH, 7, width of year field (years since 2000)
YEAR_MAX, 99, last valid year offset; the calendar wraps to 0 after it; must be <= 99 (leap rule year%4==0 holds only for 2000-2099)
RST_WDAY, 5, weekday at reset (0=Monday; 2000-01-01 is Saturday)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
en_i  in  1  calendar enable; ticks are ignored while low
tick_i  in  1  one-cycle seconds pulse
ld_valid_i  in  1  load request, single-cycle pulse
ld_sec_i / ld_min_i  in  6 each  load seconds / minutes
ld_hour_i  in  5  load hour
ld_day_i  in  5  load day of month (1-based)
ld_mon_i  in  4  load month (1-based)
ld_year_i  in  YEAR_WIDTH  load year offset
ld_wday_i  in  3  load weekday
ld_ack_o  out  1  load accepted pulse
ld_err_o  out  1  load rejected pulse
alrm_en_i  in  1  alarm enable
alrm_sec_i / alrm_min_i  in  6 each  alarm seconds / minutes
alrm_hour_i  in  5  alarm hour
alrm_o  out  1  alarm pulse
sec_o / min_o  out  6 each  current seconds / minutes
hour_o  out  5  current hour
day_o  out  5  current day of month
mon_o  out  4  current month
year_o  out  YEAR_WIDTH  current year offset
wday_o  out  3  current weekday
min_evt_o / hour_evt_o / day_evt_o  out  1 each  carry pulses
wrap_o  out  1  full-calendar wrap pulse

Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - Fields: 2000-01-01 00:00:00, i.e. sec/min/hour/year=0, day=1, mon=1, wday=RST_WDAY.
  - All pulse outputs return to 0.
  - Reset overrides any load or tick in the same cycle.
- Advance: tick_i && en_i at edge N -> all fields updated at N+1 (one-cycle latency, single-cycle full cascade).
- Cascade rules:
  - sec 59->0 increments min; min 59->0 increments hour; hour 23->0 increments day and wday.
  - wday 6->0.
  - day wraps to 1 after the month's last day: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; month 2 gives 29 if year[1:0]==0, else 28.
  - mon 12->1 increments year; year YEAR_MAX->0.
- Event pulses: registered, asserted for the cycle at N+1 alongside the updated fields.
  - min_evt_o when sec wrapped; hour_evt_o when min wrapped; day_evt_o when hour wrapped.
  - wrap_o when year wrapped from YEAR_MAX to 0.
- Load:
  - ld_valid_i is checked combinationally in the same cycle.
  - Valid when: sec<=59, min<=59, hour<=23, 1<=mon<=12, 1<=day<=days_in_month(mon, year), year<=YEAR_MAX, and wday<=6 (feature on).
  - Valid load: all fields take the load values at the next edge; ld_ack_o pulses for 1 cycle.
  - Invalid load: fields unchanged; ld_err_o pulses for 1 cycle.
  - Load is accepted regardless of en_i.
- Load and tick in the same cycle:
  - Load wins; the tick is discarded and no carry pulses are produced.
  - On an invalid load the tick is still applied.
- Alarm:
  - alrm_o pulses 1 cycle, registered, in the cycle after the fields become equal to alrm_hour/min/sec.
  - Requires alrm_en_i=1 and the match must be caused by a tick advance (not a load).
  - Alarm values out of range never match.
  - Fires at most once per matching second.
- Ticks arriving on consecutive cycles are each honoured.
- en_i low freezes fields; outputs hold.

Optional Feature:
- Macro RTC_CALENDAR_WDAY_EN.
- Defined: weekday counter implemented as described, ld_wday_i validated (<=6) and loaded.
- Undefined: no weekday register; wday_o tied to 0; ld_wday_i ignored and excluded from validation; the rest of the behaviour is identical.

Test Plan:
- Reset: assert rst_i one cycle -> fields 00:00:00, day 1, mon 1, year 0, wday 5; all pulses 0.
- Leap rollover: load 24-02-28 23:59:59, then tick -> 24-02-29 00:00:00, day_evt_o=1, min/hour_evt_o=1. Load 23-02-28 23:59:59, then tick -> 23-03-01.
- Full wrap: load 99-12-31 23:59:59 wday 4, then tick -> 00-01-01 00:00:00, wday 5, wrap_o=1 for exactly 1 cycle.
- Invalid load: ld 23-02-29 or hour 24 -> ld_err_o=1; fields unchanged. Same load arriving with a tick -> err, and the tick still advances sec.
- Collision and enable:
  - Valid load 10:00:00 together with a tick -> ack; fields exactly 10:00:00, no evt pulses.
  - en_i=0 with 5 ticks -> no change.
- Alarm: alrm 00:01:00, en=1; from 00:00:58 apply 2 ticks -> alrm_o high 1 cycle after the second tick's update. Loading 00:01:00 directly -> no alrm_o.

Source files
------------

// File: rtl/rtc_calendar.sv
// Calendar stage: advances sec/min/hour/day/month/year on a synchronised seconds tick,
// with validated load, carry pulses and a daily alarm. Weekday counter under RTC_CALENDAR_WDAY_EN.
module rtc_calendar #(
  parameter int YEAR_WIDTH = 7,
  parameter int YEAR_MAX   = 99,
  parameter int RST_WDAY   = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  tick_i,
  input  logic                  ld_valid_i,
  input  logic [5:0]            ld_sec_i,
  input  logic [5:0]            ld_min_i,
  input  logic [4:0]            ld_hour_i,
  input  logic [4:0]            ld_day_i,
  input  logic [3:0]            ld_mon_i,
  input  logic [YEAR_WIDTH-1:0] ld_year_i,
  input  logic [2:0]            ld_wday_i,
  output logic                  ld_ack_o,
  output logic                  ld_err_o,
  input  logic                  alrm_en_i,
  input  logic [5:0]            alrm_sec_i,
  input  logic [5:0]            alrm_min_i,
  input  logic [4:0]            alrm_hour_i,
  output logic                  alrm_o,
  output logic [5:0]            sec_o,
  output logic [5:0]            min_o,
  output logic [4:0]            hour_o,
  output logic [4:0]            day_o,
  output logic [3:0]            mon_o,
  output logic [YEAR_WIDTH-1:0] year_o,
  output logic [2:0]            wday_o,
  output logic                  min_evt_o,
  output logic                  hour_evt_o,
  output logic                  day_evt_o,
  output logic                  wrap_o
);

  localparam logic [YEAR_WIDTH-1:0] YMAX = YEAR_WIDTH'(YEAR_MAX);

  // Leap rule year%4==0 is exact for 2000-2099, which YEAR_MAX<=99 guarantees.
  function automatic logic [4:0] days_in_month(input logic [3:0] mon,
                                               input logic [YEAR_WIDTH-1:0] year);
    case (mon)
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      4'd2:                    days_in_month = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 days_in_month = 5'd31;
    endcase
  endfunction

  logic [5:0]            sec_q, sec_d, min_q, min_d;
  logic [4:0]            hour_q, hour_d, day_q, day_d;
  logic [3:0]            mon_q, mon_d;
  logic [YEAR_WIDTH-1:0] year_q, year_d;
  logic ack_q, ack_d, err_q, err_d;
  logic min_evt_q, min_evt_d, hour_evt_q, hour_evt_d, day_evt_q, day_evt_d;
  logic wrap_q, wrap_d, adv_q, adv_d, alrm_q, alrm_d;
  logic ld_ok, do_tick;
  logic sec_wrap, min_wrap, hour_wrap, day_wrap, mon_wrap, year_wrap;

`ifdef RTC_CALENDAR_WDAY_EN
  logic [2:0] wday_q, wday_d;
  logic       wday_ok;
  assign wday_ok = (ld_wday_i <= 3'd6);
  assign wday_o  = wday_q;
`else
  logic       wday_ok;
  logic       unused_wday;
  assign wday_ok     = 1'b1;
  assign wday_o      = 3'd0;
  assign unused_wday = ^{ld_wday_i, 3'(RST_WDAY)};
`endif

  assign ld_ok = (ld_sec_i <= 6'd59) && (ld_min_i <= 6'd59) && (ld_hour_i <= 5'd23) &&
                 (ld_mon_i >= 4'd1) && (ld_mon_i <= 4'd12) && (ld_day_i >= 5'd1) &&
                 (ld_day_i <= days_in_month(ld_mon_i, ld_year_i)) &&
                 (ld_year_i <= YMAX) && wday_ok;

  // A valid load consumes the tick; an invalid one lets it through.
  assign do_tick   = tick_i && en_i && !(ld_valid_i && ld_ok);
  assign sec_wrap  = (sec_q == 6'd59);
  assign min_wrap  = sec_wrap && (min_q == 6'd59);
  assign hour_wrap = min_wrap && (hour_q == 5'd23);
  assign day_wrap  = hour_wrap && (day_q == days_in_month(mon_q, year_q));
  assign mon_wrap  = day_wrap && (mon_q == 4'd12);
  assign year_wrap = mon_wrap && (year_q == YMAX);

  always_comb begin
    sec_d = sec_q; min_d = min_q; hour_d = hour_q;
    day_d = day_q; mon_d = mon_q; year_d = year_q;
`ifdef RTC_CALENDAR_WDAY_EN
    wday_d = wday_q;
`endif
    ack_d = 1'b0; err_d = 1'b0; adv_d = 1'b0;
    min_evt_d = 1'b0; hour_evt_d = 1'b0; day_evt_d = 1'b0; wrap_d = 1'b0;
    if (ld_valid_i && ld_ok) begin
      ack_d = 1'b1;
      sec_d = ld_sec_i; min_d = ld_min_i; hour_d = ld_hour_i;
      day_d = ld_day_i; mon_d = ld_mon_i; year_d = ld_year_i;
`ifdef RTC_CALENDAR_WDAY_EN
      wday_d = ld_wday_i;
`endif
    end else begin
      err_d = ld_valid_i;
      if (do_tick) begin
        adv_d      = 1'b1;
        min_evt_d  = sec_wrap;
        hour_evt_d = min_wrap;
        day_evt_d  = hour_wrap;
        wrap_d     = year_wrap;
        sec_d      = sec_wrap ? 6'd0 : sec_q + 6'd1;
        if (sec_wrap)  min_d  = min_wrap ? 6'd0 : min_q + 6'd1;
        if (min_wrap)  hour_d = hour_wrap ? 5'd0 : hour_q + 5'd1;
        if (hour_wrap) begin
          day_d = day_wrap ? 5'd1 : day_q + 5'd1;
`ifdef RTC_CALENDAR_WDAY_EN
          wday_d = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
`endif
        end
        if (day_wrap)  mon_d  = mon_wrap ? 4'd1 : mon_q + 4'd1;
        if (mon_wrap)  year_d = year_wrap ? '0 : year_q + 1'b1;
      end
    end
  end

  // adv_q marks the single cycle in which the fields hold a freshly ticked value.
  assign alrm_d = adv_q && alrm_en_i && (alrm_sec_i <= 6'd59) && (alrm_min_i <= 6'd59) &&
                  (alrm_hour_i <= 5'd23) && (sec_q == alrm_sec_i) &&
                  (min_q == alrm_min_i) && (hour_q == alrm_hour_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sec_q <= '0; min_q <= '0; hour_q <= '0;
      day_q <= 5'd1; mon_q <= 4'd1; year_q <= '0;
`ifdef RTC_CALENDAR_WDAY_EN
      wday_q <= 3'(RST_WDAY);
`endif
      ack_q <= 1'b0; err_q <= 1'b0; adv_q <= 1'b0; alrm_q <= 1'b0;
      min_evt_q <= 1'b0; hour_evt_q <= 1'b0; day_evt_q <= 1'b0; wrap_q <= 1'b0;
    end else begin
      sec_q <= sec_d; min_q <= min_d; hour_q <= hour_d;
      day_q <= day_d; mon_q <= mon_d; year_q <= year_d;
`ifdef RTC_CALENDAR_WDAY_EN
      wday_q <= wday_d;
`endif
      ack_q <= ack_d; err_q <= err_d; adv_q <= adv_d; alrm_q <= alrm_d;
      min_evt_q <= min_evt_d; hour_evt_q <= hour_evt_d; day_evt_q <= day_evt_d;
      wrap_q <= wrap_d;
    end
  end

  assign sec_o = sec_q;   assign min_o = min_q;   assign hour_o = hour_q;
  assign day_o = day_q;   assign mon_o = mon_q;   assign year_o = year_q;
  assign ld_ack_o = ack_q;       assign ld_err_o = err_q;   assign alrm_o = alrm_q;
  assign min_evt_o = min_evt_q;  assign hour_evt_o = hour_evt_q;
  assign day_evt_o = day_evt_q;  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_rtc_calendar.sv
// Directed-vector bench for rtc_calendar: reset, leap/month/year rollover, load
// validation, load/tick collision, enable gating and the tick-driven alarm.
module tb_rtc_calendar;

`ifdef RTC_CALENDAR_WDAY_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0, en = 1'b1, tick = 1'b0, ld_valid = 1'b0;
  logic [5:0] ld_sec = '0, ld_min = '0;
  logic [4:0] ld_hour = '0, ld_day = 5'd1;
  logic [3:0] ld_mon = 4'd1;
  logic [6:0] ld_year = '0;
  logic [2:0] ld_wday = '0;
  logic alrm_en = 1'b0;
  logic [5:0] alrm_sec = '0, alrm_min = '0;
  logic [4:0] alrm_hour = '0;
  logic ld_ack, ld_err, alrm;
  logic [5:0] sec, min;
  logic [4:0] hour, day;
  logic [3:0] mon;
  logic [6:0] year;
  logic [2:0] wday;
  logic min_evt, hour_evt, day_evt, wrap;
  int n_checks = 0, n_errors = 0;

  rtc_calendar #(.YEAR_WIDTH(7), .YEAR_MAX(99), .RST_WDAY(5)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .tick_i(tick), .ld_valid_i(ld_valid),
    .ld_sec_i(ld_sec), .ld_min_i(ld_min), .ld_hour_i(ld_hour), .ld_day_i(ld_day),
    .ld_mon_i(ld_mon), .ld_year_i(ld_year), .ld_wday_i(ld_wday),
    .ld_ack_o(ld_ack), .ld_err_o(ld_err), .alrm_en_i(alrm_en),
    .alrm_sec_i(alrm_sec), .alrm_min_i(alrm_min), .alrm_hour_i(alrm_hour),
    .alrm_o(alrm), .sec_o(sec), .min_o(min), .hour_o(hour), .day_o(day),
    .mon_o(mon), .year_o(year), .wday_o(wday), .min_evt_o(min_evt),
    .hour_evt_o(hour_evt), .day_evt_o(day_evt), .wrap_o(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dt(input int y, input int mo, input int d,
                                     input int h, input int mi, input int s);
    return {31'd0, 7'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s)};
  endfunction

  function automatic logic [63:0] cur();
    return {31'd0, year, mon, day, hour, min, sec};
  endfunction

  function automatic logic [63:0] ew(input int w);
    return WD_EN ? 64'(w) : 64'd0;
  endfunction

  // Event vector order: {min_evt, hour_evt, day_evt, wrap}
  function automatic logic [63:0] evts();
    return {60'd0, min_evt, hour_evt, day_evt, wrap};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic do_load(input int y, input int mo, input int d, input int h,
                         input int mi, input int s, input int w, input bit with_tick);
    ld_year = 7'(y); ld_mon = 4'(mo); ld_day = 5'(d);
    ld_hour = 5'(h); ld_min = 6'(mi); ld_sec = 6'(s); ld_wday = 3'(w);
    ld_valid = 1'b1;
    tick = with_tick;
    step();
    ld_valid = 1'b0;
    tick = 1'b0;
  endtask

  initial begin
    // Reset also overrides a simultaneous valid load and tick
    rst = 1'b1;
    do_load(24, 6, 15, 12, 30, 30, 1, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_fields", cur(), dt(0, 1, 1, 0, 0, 0));
    check("rst_wday", 64'(wday), ew(5));
    check("rst_pulses", {57'd0, min_evt, hour_evt, day_evt, wrap, alrm, ld_ack, ld_err}, 64'd0);

    // Leap-year February rollover
    do_load(24, 2, 28, 23, 59, 59, 2, 1'b0);
    check("leap_ld_ack", {62'd0, ld_ack, ld_err}, 64'b10);
    check("leap_ld_fields", cur(), dt(24, 2, 28, 23, 59, 59));
    step();
    check("ack_one_cycle", 64'(ld_ack), 64'd0);
    do_tick();
    check("leap_roll", cur(), dt(24, 2, 29, 0, 0, 0));
    check("leap_evts", evts(), 64'b1110);
    check("leap_wday", 64'(wday), ew(3));
    step();
    check("evts_one_cycle", evts(), 64'd0);

    // Non-leap February rollover into March
    do_load(23, 2, 28, 23, 59, 59, 1, 1'b0);
    do_tick();
    check("nonleap_roll", cur(), dt(23, 3, 1, 0, 0, 0));

    // Full calendar wrap
    do_load(99, 12, 31, 23, 59, 59, 4, 1'b0);
    do_tick();
    check("wrap_fields", cur(), dt(0, 1, 1, 0, 0, 0));
    check("wrap_wday", 64'(wday), ew(5));
    check("wrap_evts", evts(), 64'b1111);
    step();
    check("wrap_one_cycle", 64'(wrap), 64'd0);

    // Invalid loads
    do_load(23, 2, 29, 10, 0, 0, 0, 1'b0);
    check("bad_feb29_err", {62'd0, ld_ack, ld_err}, 64'b01);
    check("bad_feb29_hold", cur(), dt(0, 1, 1, 0, 0, 0));
    do_load(0, 1, 1, 24, 0, 0, 0, 1'b1);
    check("bad_hour_err", {62'd0, ld_ack, ld_err}, 64'b01);
    check("bad_hour_tick", cur(), dt(0, 1, 1, 0, 0, 1));
    do_load(0, 1, 1, 0, 0, 1, 7, 1'b0);
    check("wday7_resp", {62'd0, ld_ack, ld_err}, {62'd0, !WD_EN, WD_EN});
    check("wday7_hold", cur(), dt(0, 1, 1, 0, 0, 1));
    do_load(0, 13, 1, 0, 0, 0, 0, 1'b0);
    check("bad_mon_err", 64'(ld_err), 64'd1);
    do_load(0, 4, 31, 0, 0, 0, 0, 1'b0);
    check("bad_apr31_err", 64'(ld_err), 64'd1);

    // Load collides with a tick that would otherwise carry
    do_load(0, 1, 1, 9, 59, 59, 1, 1'b0);
    do_load(0, 1, 1, 10, 0, 0, 1, 1'b1);
    check("coll_ack", {62'd0, ld_ack, ld_err}, 64'b10);
    check("coll_fields", cur(), dt(0, 1, 1, 10, 0, 0));
    check("coll_no_evts", evts(), 64'd0);

    // Enable low freezes the calendar
    en = 1'b0;
    for (int i = 0; i < 5; i++) do_tick();
    check("en_low_hold", cur(), dt(0, 1, 1, 10, 0, 0));
    en = 1'b1;
    tick = 1'b1;
    for (int i = 0; i < 3; i++) step();
    tick = 1'b0;
    check("back_to_back", cur(), dt(0, 1, 1, 10, 0, 3));

    // Alarm from a tick advance
    alrm_hour = 5'd0; alrm_min = 6'd1; alrm_sec = 6'd0; alrm_en = 1'b1;
    do_load(0, 1, 1, 0, 0, 58, 0, 1'b0);
    do_tick();
    check("alrm_pre", 64'(alrm), 64'd0);
    do_tick();
    check("alrm_match_fields", cur(), dt(0, 1, 1, 0, 1, 0));
    check("alrm_not_yet", 64'(alrm), 64'd0);
    step();
    check("alrm_fire", 64'(alrm), 64'd1);
    step();
    check("alrm_once", 64'(alrm), 64'd0);

    // Alarm is not raised by a load
    do_load(0, 1, 1, 0, 1, 0, 0, 1'b0);
    step();
    check("alrm_load_a", 64'(alrm), 64'd0);
    step();
    check("alrm_load_b", 64'(alrm), 64'd0);

    // Alarm disabled
    alrm_en = 1'b0;
    do_load(0, 1, 1, 0, 0, 59, 0, 1'b0);
    do_tick();
    step();
    check("alrm_disabled", 64'(alrm), 64'd0);

    // Out-of-range alarm never matches, even at 00:00:00 after a wrap
    alrm_en = 1'b1; alrm_hour = 5'd24; alrm_min = 6'd0; alrm_sec = 6'd0;
    do_load(0, 1, 1, 23, 59, 59, 0, 1'b0);
    do_tick();
    step();
    check("alrm_out_of_range", 64'(alrm), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
